// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN   = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RESET_LEN = 4;

  // Saturation value of the default-width match counter.
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with
// overlap select, input qualification and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN       = DEF_MAX_LEN,
  parameter int                 LEN_W         = len_width(MAX_LEN),
  parameter int                 CNT_W         = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(4'b1011),
  parameter int                 RESET_LEN     = DEF_RESET_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic               d_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               z_q, z_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] nh;
  logic [LEN_W-1:0]   nf;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_ok;
  logic               hit;

  // Selects the low len_q bits of history/pattern for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign nh     = {hist_q[MAX_LEN-2:0], d};
  assign nf     = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign hit    = (nf >= len_q) && (((nh ^ pattern_q) & len_mask) == '0);
  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    z_d       = 1'b0;
    err_d     = 1'b0;

    if (cfg_load) begin
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (d_valid) begin
      hist_d = nh;
      z_d    = hit;
      // Non-overlapping mode restarts the fill so matched bits are not reused.
      fill_d = (hit && !overlap_q) ? '0 : nf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RESET_PATTERN;
      len_q     <= LEN_W'(RESET_LEN);
      overlap_q <= 1'b1;
      z_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      z_q       <= z_d;
      err_q     <= err_d;
    end
  end

  assign z       = z_q;
  assign cfg_err = err_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (z_d),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param; a second instance with a
// 2-bit counter shares all inputs to exercise saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d = 1'b0;
  logic       d_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        z, z2;
  logic [15:0] match_cnt;
  logic [1:0]  cnt2;
  logic        cfg_err, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(cnt2), .cfg_err(err2)
  );

  task automatic send_bit(input logic b);
    d = b;
    d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    d_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l,
                          input logic o, input logic dbit);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    cfg_load = 1'b1;
    d = dbit;
    d_valid = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    d_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (z !== 1'b0) begin bad++; $display("[TB] FAIL reset_z: got %b expected 0", z); end
    total++;
    if (match_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d expected 0", match_cnt); end
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", cfg_err); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] expz = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      total++;
      if (z !== expz[6-i]) begin bad++; $display("[TB] FAIL dflt_z bit%0d: got %b expected %b", i+1, z, expz[6-i]); end
    end
    total++;
    if (match_cnt !== 16'd2) begin bad++; $display("[TB] FAIL dflt_cnt: got %0d expected 2", match_cnt); end
    total++;
    if (cnt2 !== 2'd2) begin bad++; $display("[TB] FAIL dflt_cnt2: got %0d expected 2", cnt2); end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] expz = 7'b0001000;
    pulse_clr();
    total++;
    if (match_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_cnt: got %0d expected 0", match_cnt); end
    load_cfg(8'h0B, 4'd4, 1'b0, 1'b0);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL nov_err: got %b expected 0", cfg_err); end
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      total++;
      if (z !== expz[6-i]) begin bad++; $display("[TB] FAIL nov_z bit%0d: got %b expected %b", i+1, z, expz[6-i]); end
    end
    total++;
    if (match_cnt !== 16'd1) begin bad++; $display("[TB] FAIL nov_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_gaps();
    logic [2:0] bits = 3'b110;
    logic [2:0] expz = 3'b001;
    pulse_clr();
    load_cfg(8'h06, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_bit(bits[2-i]);
      total++;
      if (z !== expz[2-i]) begin bad++; $display("[TB] FAIL gap_z bit%0d: got %b expected %b", i+1, z, expz[2-i]); end
      for (int g = 0; g < 5; g++) begin
        idle(1);
        total++;
        if (z !== 1'b0) begin bad++; $display("[TB] FAIL gap_idle_z bit%0d gap%0d: got %b expected 0", i+1, g, z); end
      end
    end
    total++;
    if (match_cnt !== 16'd1) begin bad++; $display("[TB] FAIL gap_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_max_len();
    logic [7:0] p = 8'hA5;
    pulse_clr();
    load_cfg(p, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_bit(p[7-i]);
      total++;
      if (z !== 1'b0) begin bad++; $display("[TB] FAIL max_pre_z bit%0d: got %b expected 0", i+1, z); end
    end
    load_cfg(p, 4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(p[7-i]);
      total++;
      if (z !== (i == 7)) begin bad++; $display("[TB] FAIL max_z bit%0d: got %b expected %b", i+1, z, (i == 7)); end
    end
    total++;
    if (match_cnt !== 16'd1) begin bad++; $display("[TB] FAIL max_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_cfg_err();
    pulse_clr();
    load_cfg(8'h0B, 4'd4, 1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    load_cfg(8'h01, 4'd0, 1'b0, 1'b1);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("[TB] FAIL err_len0: got %b expected 1", cfg_err); end
    send_bit(1'b1);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse: got %b expected 0", cfg_err); end
    total++;
    if (z !== 1'b0) begin bad++; $display("[TB] FAIL err_d_ignored: got %b expected 0", z); end
    load_cfg(8'h01, 4'd9, 1'b0, 1'b1);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("[TB] FAIL err_len9: got %b expected 1", cfg_err); end
    send_bit(1'b1);
    total++;
    if (z !== 1'b1) begin bad++; $display("[TB] FAIL err_keep_z: got %b expected 1", z); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (z !== 1'b1) begin bad++; $display("[TB] FAIL err_keep_overlap: got %b expected 1", z); end
    total++;
    if (match_cnt !== 16'd2) begin bad++; $display("[TB] FAIL err_cnt: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_saturation();
    pulse_clr();
    load_cfg(8'h0B, 4'd4, 1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    for (int r = 0; r < 4; r++) begin
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    end
    total++;
    if (match_cnt !== 16'd5) begin bad++; $display("[TB] FAIL sat_cnt16: got %0d expected 5", match_cnt); end
    total++;
    if (cnt2 !== 2'd3) begin bad++; $display("[TB] FAIL sat_cnt2: got %0d expected 3", cnt2); end
    send_bit(1'b0);
    send_bit(1'b1);
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    total++;
    if (z !== 1'b1) begin bad++; $display("[TB] FAIL clr_win_z: got %b expected 1", z); end
    total++;
    if (match_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_win_cnt: got %0d expected 0", match_cnt); end
    total++;
    if (cnt2 !== 2'd0) begin bad++; $display("[TB] FAIL clr_win_cnt2: got %0d expected 0", cnt2); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits = 4'b1011;
    logic [3:0] expz = 4'b0001;
    load_cfg(8'h06, 4'd3, 1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    total++;
    if (z !== 1'b1 || match_cnt !== 16'd1) begin bad++; $display("[TB] FAIL rmid_pre: got z=%b cnt=%0d expected z=1 cnt=1", z, match_cnt); end
    rst = 1'b0;
    #2;
    total++;
    if (z !== 1'b0) begin bad++; $display("[TB] FAIL rmid_z: got %b expected 0", z); end
    total++;
    if (match_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rmid_cnt: got %0d expected 0", match_cnt); end
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("[TB] FAIL rmid_err: got %b expected 0", cfg_err); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[3-i]);
      total++;
      if (z !== expz[3-i]) begin bad++; $display("[TB] FAIL rmid_pat_z bit%0d: got %b expected %b", i+1, z, expz[3-i]); end
    end
    total++;
    if (match_cnt !== 16'd1) begin bad++; $display("[TB] FAIL rmid_post_cnt: got %0d expected 1", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_gaps();
    test_max_len();
    test_cfg_err();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
